// File: rtl/ram_sdp_v2_pkg.sv
// Shared definitions for the ram_sdp_v2 simple dual-port RAM.
// Holds the read-during-write mode encodings, the init FSM state type and a
// per-byte even-parity helper.
package ram_pkg;

  localparam int RD_READ_FIRST  = 0;
  localparam int RD_WRITE_FIRST = 1;

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } state_t;

  // Even parity: stored bit makes the 9-bit group have an even number of ones.
  function automatic logic byte_parity(input logic [7:0] b);
    return ^b;
  endfunction

endpackage

// File: rtl/ram_sdp_v2_if.sv
// Bus bundle for ram_sdp_v2: write port, read port and status outputs.
// Optional build macro: RAM_SDP_PARITY_EN adds the parity_err output.
interface ram_sdp_v2_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 6
);

  logic                  we;
  logic [DATA_W/8-1:0]   be;
  logic [ADDR_W-1:0]     write_addr;
  logic [DATA_W-1:0]     data_in;
  logic                  re;
  logic [ADDR_W-1:0]     read_addr;
  logic [DATA_W-1:0]     data_out;
  logic                  rvalid;
  logic                  init_busy;
`ifdef RAM_SDP_PARITY_EN
  logic                  parity_err;
`endif

  modport master (
    output we, be, write_addr, data_in, re, read_addr,
`ifdef RAM_SDP_PARITY_EN
    input  parity_err,
`endif
    input  data_out, rvalid, init_busy
  );

  modport slave (
    input  we, be, write_addr, data_in, re, read_addr,
`ifdef RAM_SDP_PARITY_EN
    output parity_err,
`endif
    output data_out, rvalid, init_busy
  );

endinterface

// File: rtl/ram_sdp_v2_clear.sv
// Power-up / reset clear sequencer: sweeps every address once writing zero,
// then hands the array over to normal traffic.
//
//   state | meaning
//   CLEAR | sweep in progress, counter addresses the word being zeroed
//   RUN   | sweep done, user reads/writes accepted
module ram_sdp_clear
  import ram_pkg::*;
#(
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              rst,
  output logic              clear_we,
  output logic [ADDR_W-1:0] clear_addr,
  output logic              init_busy
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

  state_t            r_state;
  logic [ADDR_W-1:0] r_cnt;
  logic              r_busy;

  // Sweep FSM: one word per cycle, exactly DEPTH cycles, restart on rst.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= CLEAR;
      r_cnt   <= '0;
      r_busy  <= 1'b1;
    end else begin
      case (r_state)
        CLEAR: begin
          r_cnt <= r_cnt + ADDR_W'(1);
          if (r_cnt == LAST_ADDR) begin
            r_state <= RUN;
            r_busy  <= 1'b0;
          end
        end
        RUN: begin
          r_cnt <= r_cnt;
        end
        default: begin
          r_state <= CLEAR;
        end
      endcase
    end
  end

  assign clear_we   = r_busy;
  assign clear_addr = r_cnt;
  assign init_busy  = r_busy;

endmodule

// File: rtl/ram_sdp_v2.sv
// Simple dual-port RAM with byte enables, selectable read-during-write
// behaviour, optional output register and a zeroing sweep after reset.
// Optional build macro: RAM_SDP_PARITY_EN stores one even-parity bit per byte
// and flags mismatches on the read data via parity_err.
module ram_sdp_v2
  import ram_pkg::*;
#(
  parameter int DATA_W  = 8,
  parameter int ADDR_W  = 6,
  parameter int RD_MODE = RD_READ_FIRST,
  parameter int OUT_REG = 0
) (
  input  logic       clk,
  input  logic       rst,
  ram_sdp_v2_if.slave bus
);

  localparam int NB    = DATA_W / 8;
  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] r_mem [DEPTH];

  logic              w_clear_we;
  logic [ADDR_W-1:0] w_clear_addr;
  logic              w_init_busy;
  logic              w_wr_en;
  logic              w_rd_en;
  logic              w_same_addr;
  logic [DATA_W-1:0] w_old_word;
  logic [DATA_W-1:0] w_merged_word;
  logic [DATA_W-1:0] w_rd_word;

  logic              r_s1_valid;
  logic [DATA_W-1:0] r_s1_data;
  logic              w_out_valid;
  logic [DATA_W-1:0] w_out_data;

  ram_sdp_clear #(.ADDR_W(ADDR_W)) u_clear (
    .clk        (clk),
    .rst        (rst),
    .clear_we   (w_clear_we),
    .clear_addr (w_clear_addr),
    .init_busy  (w_init_busy)
  );

  assign w_wr_en     = bus.we & ~w_init_busy;
  assign w_rd_en     = bus.re & ~w_init_busy;
  assign w_same_addr = w_wr_en && (bus.write_addr == bus.read_addr);
  assign w_old_word  = r_mem[bus.read_addr];

  // Forwarded view of the word: enabled bytes from data_in, the rest from the array.
  always_comb begin
    w_merged_word = w_old_word;
    for (int i = 0; i < NB; i++) begin
      if (w_same_addr && bus.be[i]) begin
        w_merged_word[i*8 +: 8] = bus.data_in[i*8 +: 8];
      end
    end
  end

  assign w_rd_word = (RD_MODE == RD_WRITE_FIRST) ? w_merged_word : w_old_word;

  // Array write: the clear sweep owns the port while busy; rst blocks all writes.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (w_clear_we) begin
        r_mem[w_clear_addr] <= '0;
      end else if (w_wr_en) begin
        for (int i = 0; i < NB; i++) begin
          if (bus.be[i]) begin
            r_mem[bus.write_addr][i*8 +: 8] <= bus.data_in[i*8 +: 8];
          end
        end
      end
    end
  end

`ifdef RAM_SDP_PARITY_EN
  logic [NB-1:0] r_par [DEPTH];
  logic [NB-1:0] w_old_par;
  logic [NB-1:0] w_merged_par;
  logic [NB-1:0] w_rd_par;
  logic [NB-1:0] r_s1_par;
  logic [NB-1:0] w_out_par;
  logic [NB-1:0] w_calc_par;

  assign w_old_par = r_par[bus.read_addr];

  // Parity forwarding mirrors the data forwarding byte for byte.
  always_comb begin
    w_merged_par = w_old_par;
    for (int i = 0; i < NB; i++) begin
      if (w_same_addr && bus.be[i]) begin
        w_merged_par[i] = byte_parity(bus.data_in[i*8 +: 8]);
      end
    end
  end

  assign w_rd_par = (RD_MODE == RD_WRITE_FIRST) ? w_merged_par : w_old_par;

  // Parity array write, in lock-step with the data array.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (w_clear_we) begin
        r_par[w_clear_addr] <= '0;
      end else if (w_wr_en) begin
        for (int i = 0; i < NB; i++) begin
          if (bus.be[i]) begin
            r_par[bus.write_addr][i] <= byte_parity(bus.data_in[i*8 +: 8]);
          end
        end
      end
    end
  end

  // Parity check on whatever sits in the output stage.
  always_comb begin
    w_calc_par = '0;
    for (int i = 0; i < NB; i++) begin
      w_calc_par[i] = byte_parity(w_out_data[i*8 +: 8]);
    end
  end

  assign bus.parity_err = w_out_valid && (w_calc_par != w_out_par);
`endif

  // First read stage: array output register; data holds when no read is taken.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_valid <= 1'b0;
      r_s1_data  <= '0;
`ifdef RAM_SDP_PARITY_EN
      r_s1_par   <= '0;
`endif
    end else begin
      r_s1_valid <= w_rd_en;
      if (w_rd_en) begin
        r_s1_data <= w_rd_word;
`ifdef RAM_SDP_PARITY_EN
        r_s1_par  <= w_rd_par;
`endif
      end
    end
  end

  if (OUT_REG != 0) begin : g_out_reg
    logic              r_s2_valid;
    logic [DATA_W-1:0] r_s2_data;
`ifdef RAM_SDP_PARITY_EN
    logic [NB-1:0]     r_s2_par;
`endif

    // Second read stage: extra output register, advances only on fresh data.
    always_ff @(posedge clk) begin
      if (rst) begin
        r_s2_valid <= 1'b0;
        r_s2_data  <= '0;
`ifdef RAM_SDP_PARITY_EN
        r_s2_par   <= '0;
`endif
      end else begin
        r_s2_valid <= r_s1_valid;
        if (r_s1_valid) begin
          r_s2_data <= r_s1_data;
`ifdef RAM_SDP_PARITY_EN
          r_s2_par  <= r_s1_par;
`endif
        end
      end
    end

    assign w_out_valid = r_s2_valid;
    assign w_out_data  = r_s2_data;
`ifdef RAM_SDP_PARITY_EN
    assign w_out_par   = r_s2_par;
`endif
  end else begin : g_out_direct
    assign w_out_valid = r_s1_valid;
    assign w_out_data  = r_s1_data;
`ifdef RAM_SDP_PARITY_EN
    assign w_out_par   = r_s1_par;
`endif
  end

  assign bus.data_out  = w_out_data;
  assign bus.rvalid    = w_out_valid;
  assign bus.init_busy = w_init_busy;

endmodule

// File: tb/tb_ram_sdp_v2.sv
// Directed bench for ram_sdp_v2: four instances cover default, OUT_REG=1 and
// the 16-bit read-first / write-first byte-enable cases.
module tb_ram_sdp_v2;

  logic clk;
  logic rst;
  int   n_pass;
  int   n_total;

  ram_sdp_v2_if #(.DATA_W(8),  .ADDR_W(6)) b0 ();
  ram_sdp_v2_if #(.DATA_W(8),  .ADDR_W(6)) b1 ();
  ram_sdp_v2_if #(.DATA_W(16), .ADDR_W(6)) b2 ();
  ram_sdp_v2_if #(.DATA_W(16), .ADDR_W(6)) b3 ();

  ram_sdp_v2 #(.DATA_W(8), .ADDR_W(6), .RD_MODE(0), .OUT_REG(0)) u0 (.clk(clk), .rst(rst), .bus(b0));
  ram_sdp_v2 #(.DATA_W(8), .ADDR_W(6), .RD_MODE(0), .OUT_REG(1)) u1 (.clk(clk), .rst(rst), .bus(b1));
  ram_sdp_v2 #(.DATA_W(16), .ADDR_W(6), .RD_MODE(0), .OUT_REG(0)) u2 (.clk(clk), .rst(rst), .bus(b2));
  ram_sdp_v2 #(.DATA_W(16), .ADDR_W(6), .RD_MODE(1), .OUT_REG(0)) u3 (.clk(clk), .rst(rst), .bus(b3));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_all();
    b0.we = 0; b0.re = 0; b0.be = '0; b0.write_addr = '0; b0.data_in = '0; b0.read_addr = '0;
    b1.we = 0; b1.re = 0; b1.be = '0; b1.write_addr = '0; b1.data_in = '0; b1.read_addr = '0;
    b2.we = 0; b2.re = 0; b2.be = '0; b2.write_addr = '0; b2.data_in = '0; b2.read_addr = '0;
    b3.we = 0; b3.re = 0; b3.be = '0; b3.write_addr = '0; b3.data_in = '0; b3.read_addr = '0;
  endtask

  task automatic test_reset();
    int n;
    bit bad_rv;
    rst = 1;
    tick();
    n_total++; if (b0.init_busy !== 1'b1) $display("FAIL reset_busy got %0b want 1", b0.init_busy); else n_pass++;
    n_total++; if (b0.rvalid !== 1'b0) $display("FAIL reset_rvalid got %0b want 0", b0.rvalid); else n_pass++;
    n_total++; if (b0.data_out !== 8'h00) $display("FAIL reset_data got %h want 00", b0.data_out); else n_pass++;
    n_total++; if (b1.data_out !== 8'h00) $display("FAIL reset_data_oreg got %h want 00", b1.data_out); else n_pass++;
    rst = 0;
    // Traffic during the sweep must be ignored.
    b0.we = 1; b0.be = 1'b1; b0.write_addr = 6'd0; b0.data_in = 8'hFF;
    b0.re = 1; b0.read_addr = 6'd0;
    n = 0;
    bad_rv = 0;
    for (int k = 0; k < 200; k++) begin
      if (b0.init_busy !== 1'b1) break;
      n++;
      if (b0.rvalid !== 1'b0) bad_rv = 1;
      tick();
    end
    idle_all();
    n_total++; if (n != 64) $display("FAIL clear_len got %0d want 64", n); else n_pass++;
    n_total++; if (bad_rv !== 1'b0) $display("FAIL clear_rvalid got %0b want 0", bad_rv); else n_pass++;
    n_total++; if (b1.init_busy !== 1'b0) $display("FAIL clear_done_oreg got %0b want 0", b1.init_busy); else n_pass++;
  endtask

  task automatic test_clear_reads();
    b0.re = 1; b0.read_addr = 6'd0;
    tick();
    n_total++; if (b0.rvalid !== 1'b1) $display("FAIL rd0_valid got %0b want 1", b0.rvalid); else n_pass++;
    n_total++; if (b0.data_out !== 8'h00) $display("FAIL rd0_data got %h want 00", b0.data_out); else n_pass++;
    b0.read_addr = 6'h3F;
    tick();
    n_total++; if (b0.data_out !== 8'h00) $display("FAIL rd3f_data got %h want 00", b0.data_out); else n_pass++;
    b0.re = 0;
    tick();
    n_total++; if (b0.rvalid !== 1'b0) $display("FAIL rd_idle_valid got %0b want 0", b0.rvalid); else n_pass++;
  endtask

  task automatic test_write_read();
    b0.we = 1; b0.be = 1'b1; b0.write_addr = 6'd5; b0.data_in = 8'hA5;
    b1.we = 1; b1.be = 1'b1; b1.write_addr = 6'd5; b1.data_in = 8'hA5;
    tick();
    b0.we = 0; b0.re = 1; b0.read_addr = 6'd5;
    b1.we = 0; b1.re = 1; b1.read_addr = 6'd5;
    tick();
    n_total++; if (b0.data_out !== 8'hA5) $display("FAIL wr_rd_data got %h want a5", b0.data_out); else n_pass++;
    n_total++; if (b0.rvalid !== 1'b1) $display("FAIL wr_rd_valid got %0b want 1", b0.rvalid); else n_pass++;
    n_total++; if (b1.rvalid !== 1'b0) $display("FAIL oreg_early_valid got %0b want 0", b1.rvalid); else n_pass++;
    b0.re = 0; b1.re = 0;
    tick();
    n_total++; if (b0.rvalid !== 1'b0) $display("FAIL wr_rd_drop got %0b want 0", b0.rvalid); else n_pass++;
    n_total++; if (b0.data_out !== 8'hA5) $display("FAIL wr_rd_hold got %h want a5", b0.data_out); else n_pass++;
    n_total++; if (b1.rvalid !== 1'b1) $display("FAIL oreg_valid got %0b want 1", b1.rvalid); else n_pass++;
    n_total++; if (b1.data_out !== 8'hA5) $display("FAIL oreg_data got %h want a5", b1.data_out); else n_pass++;
    tick();
    n_total++; if (b1.rvalid !== 1'b0) $display("FAIL oreg_drop got %0b want 0", b1.rvalid); else n_pass++;
  endtask

  task automatic test_byte_enable();
    b2.we = 1; b2.be = 2'b11; b2.write_addr = 6'd3; b2.data_in = 16'h1234;
    b3.we = 1; b3.be = 2'b11; b3.write_addr = 6'd3; b3.data_in = 16'h1234;
    tick();
    b2.be = 2'b01; b2.data_in = 16'hABCD; b2.re = 1; b2.read_addr = 6'd3;
    b3.be = 2'b01; b3.data_in = 16'hABCD; b3.re = 1; b3.read_addr = 6'd3;
    tick();
    n_total++; if (b2.data_out !== 16'h1234) $display("FAIL rdw_read_first got %h want 1234", b2.data_out); else n_pass++;
    n_total++; if (b3.data_out !== 16'h12CD) $display("FAIL rdw_write_first got %h want 12cd", b3.data_out); else n_pass++;
    n_total++; if (b3.rvalid !== 1'b1) $display("FAIL rdw_valid got %0b want 1", b3.rvalid); else n_pass++;
    // be=0 write in the same cycle as a plain read must change nothing.
    b2.be = 2'b00; b2.data_in = 16'hFFFF;
    b3.be = 2'b00; b3.data_in = 16'hFFFF;
    tick();
    n_total++; if (b2.data_out !== 16'h12CD) $display("FAIL be_later_rf got %h want 12cd", b2.data_out); else n_pass++;
    n_total++; if (b3.data_out !== 16'h12CD) $display("FAIL be_zero_wf got %h want 12cd", b3.data_out); else n_pass++;
    b2.we = 0; b3.we = 0;
    tick();
    n_total++; if (b2.data_out !== 16'h12CD) $display("FAIL be_zero_rf got %h want 12cd", b2.data_out); else n_pass++;
    b2.we = 1; b2.be = 2'b10; b2.data_in = 16'h55EE; b2.re = 0;
    tick();
    b2.we = 0; b2.re = 1;
    tick();
    n_total++; if (b2.data_out !== 16'h55CD) $display("FAIL be_high got %h want 55cd", b2.data_out); else n_pass++;
    idle_all();
    tick();
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp;
    for (int i = 0; i < 10; i++) begin
      exp = 8'h10 + 8'(i);
      b0.we = 1; b0.be = 1'b1; b0.write_addr = 6'(i); b0.data_in = exp;
      b1.we = 1; b1.be = 1'b1; b1.write_addr = 6'(i); b1.data_in = exp;
      tick();
    end
    b0.we = 0; b1.we = 0;
    for (int i = 0; i < 10; i++) begin
      b0.re = 1; b0.read_addr = 6'(i);
      b1.re = 1; b1.read_addr = 6'(i);
      tick();
      exp = 8'h10 + 8'(i);
      n_total++; if (b0.rvalid !== 1'b1 || b0.data_out !== exp)
        $display("FAIL b2b_%0d got v=%0b d=%h want v=1 d=%h", i, b0.rvalid, b0.data_out, exp); else n_pass++;
      if (i > 0) begin
        exp = 8'h10 + 8'(i - 1);
        n_total++; if (b1.rvalid !== 1'b1 || b1.data_out !== exp)
          $display("FAIL b2b_oreg_%0d got v=%0b d=%h want v=1 d=%h", i, b1.rvalid, b1.data_out, exp); else n_pass++;
      end
    end
    b0.re = 0; b1.re = 0;
    tick();
    n_total++; if (b0.rvalid !== 1'b0) $display("FAIL b2b_end got %0b want 0", b0.rvalid); else n_pass++;
    n_total++; if (b1.rvalid !== 1'b1 || b1.data_out !== 8'h19)
      $display("FAIL b2b_oreg_last got v=%0b d=%h want v=1 d=19", b1.rvalid, b1.data_out); else n_pass++;
    tick();
    n_total++; if (b1.rvalid !== 1'b0) $display("FAIL b2b_oreg_end got %0b want 0", b1.rvalid); else n_pass++;
  endtask

  task automatic test_independent();
    b0.we = 1; b0.be = 1'b1; b0.write_addr = 6'd20; b0.data_in = 8'h77;
    b0.re = 1; b0.read_addr = 6'd5;
    tick();
    n_total++; if (b0.data_out !== 8'h15) $display("FAIL indep_rd got %h want 15", b0.data_out); else n_pass++;
    b0.write_addr = 6'd5; b0.data_in = 8'h99;
    tick();
    n_total++; if (b0.data_out !== 8'h15) $display("FAIL rdw_default got %h want 15", b0.data_out); else n_pass++;
    b0.we = 0;
    tick();
    n_total++; if (b0.data_out !== 8'h99) $display("FAIL rdw_after got %h want 99", b0.data_out); else n_pass++;
    b0.read_addr = 6'd20;
    tick();
    n_total++; if (b0.data_out !== 8'h77) $display("FAIL indep_wr got %h want 77", b0.data_out); else n_pass++;
    idle_all();
  endtask

  task automatic test_rst_mid_sweep();
    int n;
    b0.we = 1; b0.be = 1'b1; b0.write_addr = 6'd63; b0.data_in = 8'hEE;
    b1.we = 1; b1.be = 1'b1; b1.write_addr = 6'd63; b1.data_in = 8'hEE;
    tick();
    b0.we = 0; b0.re = 1; b0.read_addr = 6'd63;
    b1.we = 0; b1.re = 1; b1.read_addr = 6'd63;
    tick();
    n_total++; if (b0.data_out !== 8'hEE) $display("FAIL pre_rst_rd got %h want ee", b0.data_out); else n_pass++;
    b0.re = 0; b1.re = 0;
    rst = 1;
    tick();
    n_total++; if (b0.data_out !== 8'h00) $display("FAIL run_rst_data got %h want 00", b0.data_out); else n_pass++;
    n_total++; if (b1.rvalid !== 1'b0) $display("FAIL run_rst_inflight got %0b want 0", b1.rvalid); else n_pass++;
    n_total++; if (b1.data_out !== 8'h00) $display("FAIL run_rst_stage2 got %h want 00", b1.data_out); else n_pass++;
    rst = 0;
    repeat (20) tick();
    n_total++; if (b0.init_busy !== 1'b1) $display("FAIL mid_sweep_busy got %0b want 1", b0.init_busy); else n_pass++;
    rst = 1;
    b0.we = 1; b0.be = 1'b1; b0.write_addr = 6'd40; b0.data_in = 8'h44;
    tick();
    rst = 0; b0.we = 0;
    n = 0;
    for (int k = 0; k < 200; k++) begin
      if (b0.init_busy !== 1'b1) break;
      n++;
      tick();
    end
    n_total++; if (n != 64) $display("FAIL resweep_len got %0d want 64", n); else n_pass++;
    for (int a = 0; a < 64; a++) begin
      b0.re = 1; b0.read_addr = 6'(a);
      tick();
      n_total++; if (b0.data_out !== 8'h00) $display("FAIL zero_%0d got %h want 00", a, b0.data_out); else n_pass++;
    end
    idle_all();
    tick();
  endtask

`ifdef RAM_SDP_PARITY_EN
  task automatic test_parity();
    b0.we = 1; b0.be = 1'b1; b0.write_addr = 6'd7; b0.data_in = 8'h5A;
    tick();
    b0.write_addr = 6'd8; b0.data_in = 8'h3C;
    tick();
    b0.we = 0;
    u0.r_mem[7] = u0.r_mem[7] ^ 8'h01;
    b0.re = 1; b0.read_addr = 6'd7;
    tick();
    n_total++; if (b0.rvalid !== 1'b1 || b0.parity_err !== 1'b1)
      $display("FAIL par_bad got v=%0b e=%0b want v=1 e=1", b0.rvalid, b0.parity_err); else n_pass++;
    b0.read_addr = 6'd8;
    tick();
    n_total++; if (b0.parity_err !== 1'b0) $display("FAIL par_clean got %0b want 0", b0.parity_err); else n_pass++;
    b0.read_addr = 6'd7;
    tick();
    b0.re = 0;
    tick();
    n_total++; if (b0.parity_err !== 1'b0) $display("FAIL par_idle got %0b want 0", b0.parity_err); else n_pass++;
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    n_pass = 0;
    n_total = 0;
    rst = 1;
    idle_all();
    test_reset();
    test_clear_reads();
    test_write_read();
    test_byte_enable();
    test_back_to_back();
    test_independent();
    test_rst_mid_sweep();
`ifdef RAM_SDP_PARITY_EN
    test_parity();
`endif
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
